conv_f16_f32_seq: RTL and testbench
===================================

CONV_F16_F32_SEQ -- requirements
Module: conv_f16_f32_seq

Interface
REQ-001 Parameter NAN_QUIET, default 1: when 1, NaN outputs SHALL have mantissa bit 22 forced to 1.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  Fin holds a valid half-precision operand.
REQ-005 in_ready  output  1  block accepts an operand this cycle.
REQ-006 Fin  input  16  IEEE-754 half: sign [15], exponent [14:10], mantissa [9:0].
REQ-007 out_valid  output  1  Fout holds a valid result.
REQ-008 out_ready  input  1  consumer accepts Fout this cycle.
REQ-009 Fout  output  32  IEEE-754 single result.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 An operand SHALL be accepted on any rising edge where in_valid and in_ready are both high; Fin is captured and need not stay stable afterwards.
REQ-012 FSM states SHALL be IDLE, NORM and DONE; in_ready SHALL be high in IDLE, and in DONE only when out_ready is high.
REQ-013 Classification at acceptance, with e = Fin[14:10] and m = Fin[9:0]:
  - zero: e=0, m=0
  - subnormal: e=0, m≠0
  - normal: 1≤e≤30
  - inf: e=31, m=0
  - NaN: e=31, m≠0
REQ-014 Zero SHALL produce {s, 8'd0, 23'd0}, so the sign of -0 is kept.
REQ-015 Normal SHALL produce {s, e+8'd112, m, 13'd0}; the exponent add is 8-bit and cannot overflow.
REQ-016 Inf SHALL produce {s, 8'hFF, 23'd0}.
REQ-017 NaN SHALL produce {s, 8'hFF, m, 13'd0}, with bit 22 forced to 1 when NAN_QUIET=1.
REQ-018 Zero, normal, inf and NaN SHALL go IDLE→DONE; out_valid rises on the edge after acceptance (latency 1).
REQ-019 Subnormal SHALL go IDLE→NORM and load an 11-bit working mantissa {1'b0, m} and an 8-bit working exponent of 113.
REQ-020 In NORM, each cycle SHALL shift the working mantissa left by 1 and decrement the working exponent by 1.
REQ-021 NORM→DONE SHALL occur on the edge where the shifted mantissa bit 10 becomes 1.
REQ-022 The subnormal result SHALL be {s, exp_w, mant_w[9:0], 13'd0}, with final exp_w in the range 103..112.
REQ-023 Subnormal latency SHALL be 1+k cycles from acceptance to out_valid, where k = leading zeros of m in 10 bits, plus 1 (range 1..10).
REQ-024 In DONE, out_valid SHALL be high and Fout stable until out_ready is high.
REQ-025 Backpressure: while out_ready is low, DONE SHALL hold indefinitely with no change to Fout.
REQ-026 DONE with out_ready=1 and in_valid=1 SHALL complete the transfer and accept the new operand on the same edge, with no bubble, routing per REQ-018/019.
REQ-027 DONE with out_ready=1 and in_valid=0 SHALL return to IDLE.
REQ-028 In NORM, in_ready SHALL be low and in_valid SHALL be ignored.
REQ-029 Fout SHALL be registered; no combinational path from Fin to Fout.

Reset
REQ-030 While rst_n is low: state=IDLE, out_valid=0, busy=0, Fout=32'h0, working registers cleared.
REQ-031 Reset asserted during NORM or DONE SHALL discard the in-flight operand with no partial output.
REQ-032 After rst_n rises, in_ready SHALL be 1 from the first clock edge.

Structure
REQ-033 Shared package fp_conv_pkg SHALL hold:
  - field widths (F16 exp 5 / mantissa 10; F32 exp 8 / mantissa 23)
  - biases 15 and 127, and rebias constant 112
  - the FSM state enum
  - the class enum {ZERO, SUBN, NORM, INF, NAN}
REQ-034 One combinational sub-module, f16_classify (Fin → class, sign, e, m), SHALL be used; everything else stays in conv_f16_f32_seq.

Verification
REQ-035 Fin=16'h3C00 → Fout=32'h3F800000 one cycle after acceptance; Fin=16'h7BFF → 32'h477FE000.
REQ-036 Fin=16'h0001 → 32'h33800000 with out_valid 11 cycles after acceptance; Fin=16'h0200 → 32'h38000000 after 2 cycles; Fin=16'h83FF → 32'hB87FC000.
REQ-037 Specials:
  - 16'h8000 → 32'h80000000
  - 16'h7C00 → 32'h7F800000
  - 16'hFC00 → 32'hFF800000
  - 16'h7C01 with NAN_QUIET=1 → 32'h7FC02000
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE → Fout/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 and Fin=16'h4000 → back-to-back accept, next Fout=32'h40000000.
REQ-039 Assert rst_n=0 in cycle 3 of NORM for Fin=16'h0001 → out_valid never rises for it, state=IDLE, in_ready=1 after release.
REQ-040 Random sweep of all 65536 Fin codes with random out_ready → every Fout matches the reference model bit-exactly, each code produced exactly once, in order.

Source files
------------

// File: rtl/fp_conv_pkg.sv
// Shared constants and enums for the half-to-single float converter.
package fp_conv_pkg;

  localparam int F16_EXP_W = 5;
  localparam int F16_MAN_W = 10;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;

  localparam int F16_BIAS = 15;
  localparam int F32_BIAS = 127;

  // Half exponent plus this gives the single exponent for normal operands.
  localparam logic [F32_EXP_W-1:0] REBIAS = F32_EXP_W'(F32_BIAS - F16_BIAS);
  // A half subnormal has effective exponent 1; normalization walks down from here.
  localparam logic [F32_EXP_W-1:0] SUBN_EXP_INIT = F32_EXP_W'(F32_BIAS - F16_BIAS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_DONE
  } conv_state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBN,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } f16_class_t;

endpackage

// File: rtl/f16_classify.sv
// Splits a half-precision operand into its fields and its IEEE class.
module f16_classify
  import fp_conv_pkg::*;
(
  input  logic [15:0]          f16,
  output logic [2:0]           cls,
  output logic                 sign,
  output logic [F16_EXP_W-1:0] exp_f,
  output logic [F16_MAN_W-1:0] man_f
);

  assign sign  = f16[15];
  assign exp_f = f16[14:10];
  assign man_f = f16[9:0];

  always_comb begin
    cls = CLS_NORM;
    if (exp_f == '0) begin
      cls = (man_f == '0) ? CLS_ZERO : CLS_SUBN;
    end else if (exp_f == '1) begin
      cls = (man_f == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/conv_f16_f32_seq.sv
// Sequential half-to-single converter; subnormals normalize one bit per cycle.
module conv_f16_f32_seq
  import fp_conv_pkg::*;
#(
  parameter bit NAN_QUIET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] Fin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Fout,
  output logic        busy
);

  localparam int PAD_W = F32_MAN_W - F16_MAN_W;

  logic [2:0]           cls;
  logic                 in_sign;
  logic [F16_EXP_W-1:0] in_exp;
  logic [F16_MAN_W-1:0] in_man;

  f16_classify u_classify (
    .f16   (Fin),
    .cls   (cls),
    .sign  (in_sign),
    .exp_f (in_exp),
    .man_f (in_man)
  );

  conv_state_t          state_reg;
  logic [F16_MAN_W:0]   mant_reg;
  logic [F32_EXP_W-1:0] exp_reg;
  logic                 sign_reg;
  logic [31:0]          fout_reg;

  logic                 accept;
  logic [F16_MAN_W:0]   mant_shift;
  logic [F32_EXP_W-1:0] exp_dec;
  logic [F16_MAN_W-1:0] nan_mask;
  logic [31:0]          direct_result;

  assign in_ready   = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign mant_shift = {mant_reg[F16_MAN_W-1:0], 1'b0};
  assign exp_dec    = exp_reg - 1'b1;
  assign nan_mask   = {NAN_QUIET, {(F16_MAN_W-1){1'b0}}};

  // Every class except subnormal converts in a single step.
  always_comb begin
    direct_result = '0;
    case (cls)
      CLS_ZERO: direct_result = {in_sign, 31'd0};
      CLS_NORM: direct_result = {in_sign,
                                 {{(F32_EXP_W-F16_EXP_W){1'b0}}, in_exp} + REBIAS,
                                 in_man, {PAD_W{1'b0}}};
      CLS_INF:  direct_result = {in_sign, {F32_EXP_W{1'b1}}, {F32_MAN_W{1'b0}}};
      CLS_NAN:  direct_result = {in_sign, {F32_EXP_W{1'b1}}, in_man | nan_mask, {PAD_W{1'b0}}};
      default:  direct_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      mant_reg  <= '0;
      exp_reg   <= '0;
      sign_reg  <= 1'b0;
      fout_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            sign_reg <= in_sign;
            if (cls == CLS_SUBN) begin
              state_reg <= ST_NORM;
              mant_reg  <= {1'b0, in_man};
              exp_reg   <= SUBN_EXP_INIT;
            end else begin
              state_reg <= ST_DONE;
              fout_reg  <= direct_result;
            end
          end else if ((state_reg == ST_DONE) && out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_NORM: begin
          mant_reg <= mant_shift;
          exp_reg  <= exp_dec;
          // Hidden bit reached: drop it and publish the normalized value.
          if (mant_shift[F16_MAN_W]) begin
            state_reg <= ST_DONE;
            fout_reg  <= {sign_reg, exp_dec, mant_shift[F16_MAN_W-1:0], {PAD_W{1'b0}}};
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign Fout      = fout_reg;

endmodule

// File: tb/tb_conv_f16_f32_seq.sv
// Self-checking bench: directed vectors, backpressure, reset abort, full code sweep.
module tb_conv_f16_f32_seq;

  localparam bit NQ = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Fin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Fout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  conv_f16_f32_seq #(.NAN_QUIET(NQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Fin       (Fin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Fout      (Fout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int lead_pos(input logic [9:0] m);
    int p = -1;
    for (int i = 0; i < 10; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Value-level reference: rebuild the single from the real value of the half.
  function automatic logic [31:0] ref_conv(input logic [15:0] h);
    logic        s;
    int          e;
    logic [9:0]  m;
    int          p;
    int          ex;
    logic [22:0] frac;
    s = h[15];
    e = int'(h[14:10]);
    m = h[9:0];
    if (e == 31) begin
      if (m == 10'd0) return {s, 8'hFF, 23'd0};
      if (NQ) m[9] = 1'b1;
      return {s, 8'hFF, m, 13'd0};
    end
    if (e == 0 && m == 10'd0) return {s, 31'd0};
    if (e == 0) begin
      p    = lead_pos(m);
      ex   = 127 - 24 + p;
      frac = 23'((int'(m) - (1 << p)) << (23 - p));
    end else begin
      ex   = e - 15 + 127;
      frac = {m, 13'd0};
    end
    return {s, 8'(ex), frac};
  endfunction

  typedef struct {
    logic [15:0] code;
    logic [31:0] result;
    int          lat;
  } vec_t;

  vec_t vecs[9] = '{
    '{16'h3C00, 32'h3F800000, 1},
    '{16'h7BFF, 32'h477FE000, 1},
    '{16'h0001, 32'h33800000, 11},
    '{16'h0200, 32'h38000000, 2},
    '{16'h83FF, 32'hB87FC000, 2},
    '{16'h8000, 32'h80000000, 1},
    '{16'h7C00, 32'h7F800000, 1},
    '{16'hFC00, 32'hFF800000, 1},
    '{16'h7C01, 32'h7FC02000, 1}
  };

  task automatic run_one(input logic [15:0] code, input logic [31:0] want, input int want_lat);
    int lat;
    @(negedge clk);
    Fin = code; in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(want_lat));
    check_eq("fout", Fout, want);
    $display("tx Fin=%h Fout=%h latency=%0d", code, Fout, lat);
  endtask

  initial begin
    logic [15:0] q[$];
    logic [31:0] held;
    int          next_code;
    int          n_out;
    int          cycles;
    bit          seen_valid;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Fin = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fout", Fout, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_one(vecs[i].code, vecs[i].result, vecs[i].lat);

    // Backpressure: hold result in DONE, then hand off back-to-back.
    @(negedge clk);
    Fin = 16'h3C00; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    held = Fout;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_fout", Fout, 32'h3F800000);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      if (i < 4) @(negedge clk);
    end
    check_eq("bp_stable", Fout, held);
    out_ready = 1'b1; in_valid = 1'b1; Fin = 16'h4000;
    #1 check_eq("bp_ready_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("b2b_valid", 32'(out_valid), 32'd1);
    check_eq("b2b_fout", Fout, 32'h40000000);
    $display("tx Fin=4000 Fout=%h after backpressure", Fout);

    // Reset during normalization discards the operand.
    @(negedge clk);
    Fin = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("norm_busy", 32'(busy), 32'd1);
    check_eq("norm_no_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_fout", Fout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check_eq("abort_never_valid", 32'(seen_valid), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    $display("tx Fin=0001 aborted by reset");

    // Every code in order with random backpressure.
    next_code = 0; n_out = 0; cycles = 0;
    while (n_out < 65536 && cycles < 200000) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(15) != 0);
      in_valid  = (next_code < 65536);
      Fin       = 16'(next_code);
      #1;
      if (out_valid && out_ready) begin
        check_eq("sweep_expected_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          check_eq("sweep_fout", Fout, ref_conv(q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(Fin);
        next_code++;
      end
    end
    check_eq("sweep_count", 32'(n_out), 32'd65536);
    check_eq("sweep_leftover", 32'(q.size()), 32'd0);
    $display("tx sweep done: %0d results in %0d cycles", n_out, cycles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
